// File: rtl/pulse_width_meter_if.sv
// Result stream of pulse_width_meter: one measured width per transfer, valid/ready handshake.
interface pulse_width_meter_if #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
);
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_width;
  logic [CH_W-1:0]  m_ch;
  logic             m_sat;

  modport master (output m_valid, m_width, m_ch, m_sat, input m_ready);
  modport slave  (input m_valid, m_width, m_ch, m_sat, output m_ready);
endinterface

// File: rtl/pulse_width_meter.sv
// Multi-channel pulse width meter: per-channel counter FSMs, one-deep result slots, round-robin merge.
// Optional: define PWM_SYNC_EN to add a 2-flop synchroniser on every pulse_in bit.
module pulse_width_meter #(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 16,
  parameter int                MIN_WIDTH  = 2,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    pulse_in,
  output logic [NUM_CH-1:0]    active,
  output logic [NUM_CH-1:0]    overflow,
  input  logic                 clr_ovf,
  pulse_width_meter_if.master  res
);
  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W:0]   MIN_THR = (CNT_W+1)'(MIN_WIDTH);

  typedef enum logic [1:0] {ARM, IDLE, MEAS} ch_state_e;

  // Returns {blocked, value}: blocked is set when the count is already all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == MAX_CNT) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  function automatic logic reached(input logic [CNT_W-1:0] c);
    return {1'b0, c} >= MIN_THR;
  endfunction

  logic [NUM_CH-1:0] lvl;

  // Stage p0/p1: optional input synchroniser, reset to the idle level of each channel
`ifdef PWM_SYNC_EN
  logic [NUM_CH-1:0] sync_p0, sync_p1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= ACTIVE_LOW;
      sync_p1 <= ACTIVE_LOW;
    end else begin
      sync_p0 <= pulse_in;
      sync_p1 <= sync_p0;
    end
  end
  assign lvl = sync_p1 ^ ACTIVE_LOW;
`else
  assign lvl = pulse_in ^ ACTIVE_LOW;
`endif

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W:0]    inc     [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d, post, active_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_inc
    assign inc[g] = sat_inc(cnt_q[g]);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      sat_d[i]   = sat_q[i];
      post[i]    = 1'b0;
      unique case (state_q[i])
        ARM:  if (!lvl[i]) state_d[i] = IDLE;
        IDLE: begin
          if (lvl[i]) begin
            state_d[i] = MEAS;
            cnt_d[i]   = CNT_W'(1);
            sat_d[i]   = 1'b0;
          end
        end
        MEAS: begin
          if (lvl[i]) begin
            cnt_d[i] = inc[i][CNT_W-1:0];
            sat_d[i] = sat_q[i] | inc[i][CNT_W];
          end else begin
            // Pulses shorter than MIN_WIDTH are glitches and vanish here.
            state_d[i] = IDLE;
            post[i]    = reached(cnt_q[i]);
          end
        end
        default: state_d[i] = ARM;
      endcase
      active_d[i] = (state_d[i] == MEAS) && reached(cnt_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= ARM;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
      active <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    sat_q <= sat_d;
  end

  // Stage p0: per-channel holding slot and round-robin grant
  logic [CNT_W-1:0]  slot_w_p0 [NUM_CH];
  logic [NUM_CH-1:0] slot_sat_p0, pending_p0, grant, slot_load, ovf_set;
  logic [CH_W-1:0]   last, gnt_idx;
  logic              gnt_any, load, vld_p1;
  logic [CNT_W-1:0]  width_p1;
  logic [CH_W-1:0]   ch_p1;
  logic              sat_p1;

  assign load      = !vld_p1 || res.m_ready;
  assign slot_load = post & (~pending_p0 | grant);
  assign ovf_set   = post & pending_p0 & ~grant;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (load && !gnt_any && pending_p0[(int'(last) + 1 + j) % NUM_CH]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'((int'(last) + 1 + j) % NUM_CH);
        grant[(int'(last) + 1 + j) % NUM_CH] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_p0 <= '0;
      overflow   <= '0;
    end else begin
      pending_p0 <= (pending_p0 & ~grant) | post;
      overflow   <= (overflow & ~{NUM_CH{clr_ovf}}) | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (slot_load[i]) begin
        slot_w_p0[i]   <= cnt_q[i];
        slot_sat_p0[i] <= sat_q[i];
      end
    end
  end

  // Stage p1: output register, frozen while a result waits for m_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      width_p1 <= '0;
      ch_p1    <= '0;
      sat_p1   <= 1'b0;
      last     <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        width_p1 <= slot_w_p0[gnt_idx];
        ch_p1    <= gnt_idx;
        sat_p1   <= slot_sat_p0[gnt_idx];
        last     <= gnt_idx;
      end
    end
  end

  assign res.m_valid = vld_p1;
  assign res.m_width = width_p1;
  assign res.m_ch    = ch_p1;
  assign res.m_sat   = sat_p1;
endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: 4 channels, 8-bit counts, MIN_WIDTH 3, channel 1 active-low.
module tb_pulse_width_meter;
  localparam int         NUM_CH     = 4;
  localparam int         CNT_W      = 8;
  localparam int         MIN_WIDTH  = 3;
  localparam logic [3:0] ACTIVE_LOW = 4'b0010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] lvl = 4'b0000;
  logic [3:0] pulse_in, active, overflow;

  assign pulse_in = lvl ^ ACTIVE_LOW;

  pulse_width_meter_if #(.CNT_W(CNT_W), .CH_W(2)) res_if ();

  pulse_width_meter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_WIDTH(MIN_WIDTH), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .active(active),
    .overflow(overflow), .clr_ovf(clr_ovf), .res(res_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int got_w[$], got_ch[$], got_sat[$], got_cyc[$];

  // Transfer log: one entry per accepted result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && res_if.m_valid && res_if.m_ready) begin
      got_w.push_back(int'(res_if.m_width));
      got_ch.push_back(int'(res_if.m_ch));
      got_sat.push_back(int'(res_if.m_sat));
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch, input int n);
    lvl[ch] = 1'b1;
    tick(n);
    lvl[ch] = 1'b0;
  endtask

  task automatic clear_log();
    got_w.delete();
    got_ch.delete();
    got_sat.delete();
    got_cyc.delete();
  endtask

  task automatic check_res(input string tag, input int idx, input int w, input int ch, input int sat);
    if (idx < got_w.size()) begin
      check({tag, "_width"}, got_w[idx], w);
      check({tag, "_ch"}, got_ch[idx], ch);
      check({tag, "_sat"}, got_sat[idx], sat);
    end else begin
      check({tag, "_missing"}, got_w.size(), idx + 1);
    end
  endtask

  initial begin
    res_if.m_ready = 1'b1;
    tick(2);
    check("rst_active", active, 0);
    check("rst_valid", res_if.m_valid, 0);
    check("rst_width", res_if.m_width, 0);
    check("rst_ch", res_if.m_ch, 0);
    check("rst_sat", res_if.m_sat, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    tick(2);

    // Channel 0, 5-cycle pulse: exact active and result timing
    lvl[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check("t1_active0", active[0], (i >= 3));
    end
    lvl[0] = 1'b0;
    tick(1);
    check("t1_active0_fall", active[0], 0);
    check("t1_valid_k", res_if.m_valid, 0);
    tick(1);
    check("t1_valid_k1", res_if.m_valid, 1);
    check("t1_width", res_if.m_width, 5);
    check("t1_ch", res_if.m_ch, 0);
    check("t1_sat", res_if.m_sat, 0);
    tick(1);
    check("t1_valid_drop", res_if.m_valid, 0);

    // Channel 1 (active-low): glitch then a real pulse
    clear_log();
    pulse(1, 2);
    tick(5);
    check("t2_glitch_n", got_w.size(), 0);
    clear_log();
    pulse(1, 7);
    tick(4);
    check("t2_n", got_w.size(), 1);
    check_res("t2", 0, 7, 1, 0);

    // Fresh reset so the arbiter starts at channel 0; three simultaneous ends, twice
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    for (int rep = 0; rep < 2; rep++) begin
      clear_log();
      lvl = 4'b1101;
      tick(4);
      lvl = 4'b0000;
      tick(6);
      check("t3_n", got_w.size(), 3);
      check_res("t3_r0", 0, 4, 0, 0);
      check_res("t3_r1", 1, 4, 2, 0);
      check_res("t3_r2", 2, 4, 3, 0);
      if (got_cyc.size() == 3) begin
        check("t3_b2b_01", got_cyc[1] - got_cyc[0], 1);
        check("t3_b2b_12", got_cyc[2] - got_cyc[1], 1);
      end
    end

    // Backpressure: 4 held on output, 5 in slot, 6 dropped
    clear_log();
    res_if.m_ready = 1'b0;
    pulse(2, 4);
    tick(1);
    pulse(2, 5);
    tick(1);
    pulse(2, 6);
    tick(3);
    check("t4_valid", res_if.m_valid, 1);
    check("t4_width", res_if.m_width, 4);
    check("t4_ch", res_if.m_ch, 2);
    check("t4_ovf", overflow, 4'b0100);
    check("t4_none_yet", got_w.size(), 0);
    tick(3);
    check("t4_hold", res_if.m_width, 4);
    res_if.m_ready = 1'b1;
    tick(4);
    check("t4_n", got_w.size(), 2);
    check_res("t4_r0", 0, 4, 2, 0);
    check_res("t4_r1", 1, 5, 2, 0);
    check("t4_ovf_sticky", overflow, 4'b0100);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("t4_ovf_clr", overflow, 0);

    // Saturation on channel 3
    clear_log();
    pulse(3, 300);
    tick(4);
    check("t5_n", got_w.size(), 1);
    check_res("t5", 0, 255, 3, 1);

    // Async reset mid-handshake, then a pulse already high at reset release
    clear_log();
    res_if.m_ready = 1'b0;
    pulse(2, 4);
    tick(2);
    check("t6_pre_valid", res_if.m_valid, 1);
    lvl[0] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", res_if.m_valid, 0);
    check("t6_async_width", res_if.m_width, 0);
    res_if.m_ready = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check("t6_arm_active", active[0], 0);
    lvl[0] = 1'b0;
    tick(5);
    check("t6_arm_n", got_w.size(), 0);
    pulse(0, 3);
    tick(4);
    check("t6_n", got_w.size(), 1);
    check_res("t6", 0, 3, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Multi-channel, parametrised pulse width measurement block. Each of `NUM_CH` inputs runs an independent counter and state machine. Qualified pulse widths go into a per-channel holding slot, then a round-robin arbiter merges them onto one valid/ready result stream. Per-channel `active` levels replace the single-channel threshold output of the previous generation. The block sits between external event inputs and a register or DMA front end.

## Interface
- `NUM_CH`, 4: number of input channels (1–16).
- `CNT_W`, 16: width counter / result width (4–32).
- `MIN_WIDTH`, 2: shortest width in cycles reported and flagged `active`; shorter pulses are glitches (≥1).
- `ACTIVE_LOW`, 0: `NUM_CH`-bit mask; bit i set means channel i pulses are low-level.
- `CH_W`, derived: max(1, clog2(`NUM_CH`)).

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  `NUM_CH`  raw channel inputs.
- `active`  out  `NUM_CH`  channel i is in a pulse that has reached `MIN_WIDTH`.
- `m_valid`  out  1  result available.
- `m_ready`  in  1  consumer accepts result.
- `m_width`  out  `CNT_W`  measured width in cycles.
- `m_ch`  out  `CH_W`  source channel.
- `m_sat`  out  1  width saturated at 2^`CNT_W`−1.
- `overflow`  out  `NUM_CH`  sticky: a result was dropped on channel i.
- `clr_ovf`  in  1  clears all `overflow` bits (single cycle).

## Operation
- Per channel: level `lvl = pulse_in[i] ^ ACTIVE_LOW[i]` (after optional sync, see Configuration).
- Channel FSM states:
  - ARM: wait for `lvl==0`, then go to IDLE. This is the reset state, so a pulse already in progress at reset release is never measured.
  - IDLE: on `lvl==1`, count←1, go to MEAS.
  - MEAS: while `lvl==1`, count increments, saturating at all-ones; the sat bit is set when an increment is blocked.
  - MEAS end: on `lvl==0`, if count ≥ `MIN_WIDTH` post the result to the slot; otherwise discard silently. Go to IDLE.
- `active[i]` = state MEAS and count ≥ `MIN_WIDTH`, registered.
- Slot: one entry {width, sat} plus a pending bit per channel.
  - Posting to a free slot sets pending.
  - Posting while pending is still set and the slot is not granted that cycle drops the new result (old one kept) and sets `overflow[i]`.
  - Posting in the same cycle the slot is granted refills the slot; this is not an overflow.
- Arbiter: the output register loads when `!m_valid || m_ready`.
  - Grants the first pending channel searching upward from (last granted + 1) mod `NUM_CH`.
  - After reset, search starts at channel 0.
  - Grant clears that pending bit.
- Handshake: `m_width/m_ch/m_sat` stay stable while `m_valid && !m_ready`. Transfer happens on `m_valid && m_ready`. Back-to-back transfers run one per cycle.
- `clr_ovf` and a same-cycle overflow event: the set wins.

## Timing
- Reset values:
  - `active`=0, `m_valid`=0, `m_width`=0, `m_ch`=0, `m_sat`=0, `overflow`=0.
  - All FSMs in ARM, pending=0, arbiter pointer=last=`NUM_CH`−1.
- Width = number of rising edges sampling `lvl==1`.
- Latency: let edge k be the first sample with `lvl==0`.
  - Pending is set at edge k.
  - `m_valid` rises after edge k+1 if the output register is free and the channel wins arbitration.
- `active[i]` rises after the edge where count reaches `MIN_WIDTH`. It falls after edge k.
- `reset_n` assertion mid-pulse or mid-handshake immediately clears all state. Pending and in-flight results are lost.

## Configuration
- `PWM_SYNC_EN` defined:
  - each `pulse_in` bit passes a 2-flop synchroniser before the FSM;
  - all latencies above grow by 2 cycles;
  - widths are unchanged.
- Not defined: `pulse_in` must be synchronous to `clk` and is sampled directly.

## Test plan
Common settings: `NUM_CH`=4, `CNT_W`=8, `MIN_WIDTH`=3, `ACTIVE_LOW`=4'b0010, sync off.
- Channel 0 high for 5 cycles, `m_ready`=1 → `m_width`=5, `m_ch`=0, `m_sat`=0, `m_valid` one cycle. `active[0]` is high for cycles 3–5 of the pulse.
- Channel 1 low for 2 cycles (a glitch) → no result. Channel 1 low for 7 cycles → `m_width`=7, `m_ch`=1.
- Channels 0, 2, 3 end 4-cycle pulses on the same edge, `m_ready`=1 → three results on consecutive cycles, `m_ch` order 0, 2, 3. Repeating this gives the order 0, 2, 3 again, pointer after 3.
- `m_ready`=0 while channel 2 completes three pulses of widths 4, 5, 6 → output holds 4. Width 5 stays in the slot. Width 6 is dropped and `overflow[2]`=1. Raise `m_ready` → 4 then 5 are delivered. `clr_ovf` → `overflow`=0.
- Channel 3 high 300 cycles → `m_width`=255, `m_sat`=1.
- Channel 0 held high through `reset_n` release, then falls after 4 cycles → no result. The next 3-cycle pulse → `m_width`=3.
